// File: rtl/bit_serial_addsub.sv
// Serial adder/subtractor: operands taken over valid/ready, summed LSB-first SLICE bits per cycle
// with a registered carry; result, carry-out and signed overflow held until the consumer accepts.
module bit_serial_addsub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLICE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_out_o,
    output logic             overflow_o,
    output logic             busy_o
);

    localparam int unsigned NSlices = (SLICE == 0) ? 1 : WIDTH / SLICE;
    localparam int unsigned CntW    = (NSlices > 1) ? $clog2(NSlices) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NSlices - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    if (WIDTH < 2 || SLICE == 0 || (WIDTH % SLICE) != 0) begin : g_param_check
        $error("bit_serial_addsub: WIDTH must be >= 2 and a multiple of SLICE");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;

    logic [SLICE:0]   slice_sum;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] b_eff;

    // One slice of the ripple: low SLICE bits of each operand plus the carry from the previous slice.
    always_comb begin
        slice_sum = {1'b0, a_sh_q[SLICE-1:0]} + {1'b0, b_sh_q[SLICE-1:0]}
                  + {{SLICE{1'b0}}, carry_q};
        res_next = res_sh_q >> SLICE;
        res_next[WIDTH-1 -: SLICE] = slice_sum[SLICE-1:0];
    end

    assign b_eff = sub_i ? ~b_i : b_i;

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        sum_d    = sum_q;
        co_d     = co_q;
        ov_d     = ov_q;

        case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_sh_d   = a_i;
                    b_sh_d   = b_eff;
                    res_sh_d = '0;
                    carry_d  = sub_i;
                    cnt_d    = '0;
                    a_msb_d  = a_i[WIDTH-1];
                    b_msb_d  = b_eff[WIDTH-1];
                    state_d  = StRun;
                end
            end
            StRun: begin
                a_sh_d   = a_sh_q >> SLICE;
                b_sh_d   = b_sh_q >> SLICE;
                res_sh_d = res_next;
                carry_d  = slice_sum[SLICE];
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    sum_d   = res_next;
                    co_d    = slice_sum[SLICE];
                    ov_d    = (a_msb_q == b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            sum_q    <= '0;
            co_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            sum_q    <= sum_d;
            co_q     <= co_d;
            ov_q     <= ov_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign busy_o      = (state_q == StRun);
    assign sum_o       = sum_q;
    assign carry_out_o = co_q;
    assign overflow_o  = ov_q;

endmodule
